// File: rtl/rd_target_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rd_target_pkg: default sizes and the READ/DELAY phase encoding.           |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
package rd_target_pkg;

  localparam int c_DATA_W = 8;
  localparam int c_DEPTH  = 16;
  localparam int c_WAIT_W = 3;

  typedef enum logic [0:0] {
    P_FIRST  = 1'b0,
    P_SECOND = 1'b1
  } phase_e;

endpackage : rd_target_pkg
`default_nettype wire

// File: rtl/rd_target_mem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rd_target_mem: 1W/1R synchronous memory, read-before-write, held output.  |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module rd_target_mem
  import rd_target_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int DEPTH  = c_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking read of r_mem yields the pre-write word on an address clash.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= r_mem[rd_addr];
    end
  end

endmodule : rd_target_mem
`default_nettype wire

// File: rtl/rd_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rd_target: wait-state read target for a READ/DELAY pair controller.       |
// | Optional rpar output (parity of rdata) with macro RD_TARGET_PARITY_EN.    |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module rd_target
  import rd_target_pkg::*;
#(
  parameter int DATA_W = c_DATA_W,
  parameter int DEPTH  = c_DEPTH,
  parameter int WAIT_W = c_WAIT_W
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     rd,
  input  logic                     ds,
  output logic                     ws,
  input  logic [WAIT_W-1:0]        wait_cfg,
  input  logic                     addr_load,
  input  logic [$clog2(DEPTH)-1:0] addr_in,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid,
  output logic                     busy,
  output logic                     err,
  input  logic                     err_clr
`ifdef RD_TARGET_PARITY_EN
  ,
  output logic                     rpar
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]     c_PTR_ONE = AW'(1);
  localparam logic [WAIT_W-1:0] c_CNT_ONE = WAIT_W'(1);

  phase_e            r_phase;
  logic              r_busy;
  logic [WAIT_W-1:0] r_cnt;
  logic [AW-1:0]     r_ptr;
  logic              r_rvalid;
  logic              r_err;

  logic w_err_rd;
  logic w_err_ds;
  logic w_abort;
  logic w_fire;

  // Protocol violations take priority over any normal phase progress.
  assign w_err_rd = r_busy & ~rd;
  assign w_err_ds = ds & (r_busy | (r_phase == P_SECOND));
  assign w_abort  = w_err_rd | w_err_ds;
  assign w_fire   = ~w_abort & rd & (r_phase == P_SECOND) & (r_cnt == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_phase  <= P_FIRST;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_fire;

      if (w_abort) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end

      if (w_abort) begin
        r_phase <= P_FIRST;
        r_busy  <= 1'b0;
        r_cnt   <= '0;
      end else if (rd) begin
        case (r_phase)
          P_FIRST: begin
            r_phase <= P_SECOND;
            // wait_cfg is captured only when a new transaction opens.
            if (!r_busy) begin
              r_cnt  <= wait_cfg;
              r_busy <= 1'b1;
            end
          end
          default: begin
            r_phase <= P_FIRST;
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - c_CNT_ONE;
            end else begin
              r_busy <= 1'b0;
              r_ptr  <= r_ptr + c_PTR_ONE;
            end
          end
        endcase
      end else if (addr_load && !r_busy) begin
        r_ptr <= addr_in;
      end
    end
  end

  assign ws     = (r_phase == P_SECOND) & (r_cnt != '0);
  assign busy   = r_busy;
  assign rvalid = r_rvalid;
  assign err    = r_err;

  rd_target_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (w_fire),
    .rd_addr (r_ptr),
    .rdata   (rdata)
  );

`ifdef RD_TARGET_PARITY_EN
  // rdata is itself a register, so this tracks it exactly and is 0 in reset.
  assign rpar = ^rdata;
`endif

endmodule : rd_target
`default_nettype wire

// File: tb/tb_rd_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rd_target: directed self-checking bench for rd_target.                 |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_rd_target;

  logic       clock;
  logic       reset_n;
  logic       rd;
  logic       ds;
  logic       ws;
  logic [2:0] wait_cfg;
  logic       addr_load;
  logic [3:0] addr_in;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rdata;
  logic       rvalid;
  logic       busy;
  logic       err;
  logic       err_clr;
`ifdef RD_TARGET_PARITY_EN
  logic       rpar;
`endif

  int n_checks = 0;
  int n_errors = 0;

  rd_target #(
    .DATA_W (8),
    .DEPTH  (16),
    .WAIT_W (3)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd        (rd),
    .ds        (ds),
    .ws        (ws),
    .wait_cfg  (wait_cfg),
    .addr_load (addr_load),
    .addr_in   (addr_in),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
`ifdef RD_TARGET_PARITY_EN
    ,
    .rpar      (rpar)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic mem_write(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_ptr(input logic [3:0] a);
    addr_load = 1'b1; addr_in = a;
    tick();
    addr_load = 1'b0;
  endtask

  // One full transaction; optional addr_load during DELAY cycles (must be
  // ignored) and an optional write landing in the data-return cycle.
  task automatic txn(input int wcfg, input logic [7:0] exp, input bit load_mid,
                     input bit wr_fire, input logic [3:0] wa, input logic [7:0] wval);
    wait_cfg = 3'(wcfg);
    for (int p = 0; p <= wcfg; p++) begin
      rd = 1'b1;
      tick();
      wait_cfg = ~3'(wcfg);
      check("busy_mid", 32'(busy), 32'd1);
      check("ws_delay", 32'(ws), 32'(p < wcfg));
      if (load_mid) begin
        addr_load = 1'b1; addr_in = 4'd3;
      end
      if (wr_fire && p == wcfg) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wval;
      end
      tick();
      addr_load = 1'b0; wr_en = 1'b0;
    end
    rd = 1'b0; ds = 1'b1;
    check("rvalid_pulse", 32'(rvalid), 32'd1);
    check("rdata", 32'(rdata), 32'(exp));
    check("busy_end", 32'(busy), 32'd0);
`ifdef RD_TARGET_PARITY_EN
    check("rpar", 32'(rpar), 32'(^exp));
`endif
    tick();
    ds = 1'b0;
    check("rvalid_one", 32'(rvalid), 32'd0);
    check("err_clean", 32'(err), 32'd0);
    check("rdata_hold", 32'(rdata), 32'(exp));
  endtask

  initial begin
    reset_n = 1'b0; rd = 1'b0; ds = 1'b0; wait_cfg = '0; addr_load = 1'b0;
    addr_in = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; err_clr = 1'b0;
    #3;
    check("rst_ws", 32'(ws), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    mem_write(4'd0, 8'h11);
    mem_write(4'd1, 8'h22);
    mem_write(4'd2, 8'h33);
    mem_write(4'd3, 8'h44);
    mem_write(4'd15, 8'hA5);

    txn(0, 8'h11, 1'b0, 1'b0, 4'd0, 8'h00);
    txn(3, 8'h22, 1'b0, 1'b0, 4'd0, 8'h00);
    tick(); tick(); tick();
    check("rdata_idle_hold", 32'(rdata), 32'h22);

    // Pointer wrap from 15 to 0.
    load_ptr(4'd15);
    txn(0, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00);
    txn(0, 8'h11, 1'b0, 1'b0, 4'd0, 8'h00);
    // addr_load while busy (including the increment cycle) is ignored.
    txn(0, 8'h22, 1'b1, 1'b0, 4'd0, 8'h00);

    // rd dropped mid-transaction: ptr stays at 2.
    wait_cfg = 3'd2; rd = 1'b1;
    tick(); tick(); tick();
    rd = 1'b0;
    tick();
    check("drop_err", 32'(err), 32'd1);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_rvalid", 32'(rvalid), 32'd0);
    check("drop_ws", 32'(ws), 32'd0);
    tick();
    check("drop_rvalid2", 32'(rvalid), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errclr", 32'(err), 32'd0);
    txn(0, 8'h33, 1'b0, 1'b0, 4'd0, 8'h00);

    // err_clr together with a new error leaves err set.
    wait_cfg = 3'd0; rd = 1'b1;
    tick();
    rd = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_vs_err", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("errclr2", 32'(err), 32'd0);

    // ds while busy is a protocol error.
    rd = 1'b1;
    tick();
    ds = 1'b1;
    tick();
    rd = 1'b0; ds = 1'b0;
    check("ds_err", 32'(err), 32'd1);
    check("ds_busy", 32'(busy), 32'd0);
    check("ds_rvalid", 32'(rvalid), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Write to the address being read in the return cycle: old data first.
    txn(1, 8'h44, 1'b0, 1'b1, 4'd3, 8'h5C);
    load_ptr(4'd3);
    txn(0, 8'h5C, 1'b0, 1'b0, 4'd0, 8'h00);

    // Asynchronous reset mid-transaction (ptr 4, ws high at this point).
    wait_cfg = 3'd2; rd = 1'b1;
    tick(); tick(); tick();
    check("pre_rst_ws", 32'(ws), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ws", 32'(ws), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'd0);
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    rd = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    check("post_rst_err", 32'(err), 32'd0);
    check("post_rst_rvalid", 32'(rvalid), 32'd0);
    txn(0, 8'h11, 1'b0, 1'b0, 4'd0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_rd_target
`default_nettype wire

// File: doc/rd_target.md
RD_TARGET -- requirements
Module: rd_target

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the data word width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of memory words; it SHALL be a power of 2.
REQ-003 SHALL have parameter WAIT_W, default 3, meaning the width of the wait-count configuration.
REQ-004 Ports SHALL be, in this order:
  clock  in  1  sole clock; all logic on posedge.
  reset_n  in  1  asynchronous, active-low reset.
  rd  in  1  read strobe from the upstream read controller; held high for a whole transaction.
  ds  in  1  done strobe from the controller; one cycle, after the transaction.
  ws  out  1  wait-state request to the controller; 1 requests another READ/DELAY pass.
  wait_cfg  in  WAIT_W  number of extra passes before data is returned.
  addr_load  in  1  loads the read pointer from addr_in.
  addr_in  in  log2(DEPTH)  new read-pointer value.
  wr_en  in  1  memory write enable.
  wr_addr  in  log2(DEPTH)  write address.
  wr_data  in  DATA_W  write data.
  rdata  out  DATA_W  returned read data.
  rvalid  out  1  one-cycle pulse marking rdata valid.
  busy  out  1  a transaction is in progress.
  err  out  1  sticky protocol-error flag.
  err_clr  in  1  clears err.

Function
REQ-005 Protocol: controller asserts rd for consecutive pairs of cycles (READ, then DELAY); it samples ws in the DELAY cycle; ws=1 starts another pair, ws=0 ends rd and gives a single ds cycle.
REQ-006 Internal state: busy, phase bit, wait counter cnt (WAIT_W bits), read pointer ptr.
REQ-007 ws SHALL equal phase AND (cnt != 0), decoded from registers only, with no combinational path from any input.
REQ-008 Phase-0 cycle with rd=1: phase<=1; if busy=0, then cnt<=wait_cfg and busy<=1. wait_cfg SHALL be sampled only at this point.
REQ-009 Phase-1 cycle with rd=1: phase<=0; if cnt!=0, then cnt<=cnt-1.
REQ-010 Phase-1 cycle with rd=1 and cnt==0: rdata<=mem[ptr]; rvalid<=1 for one cycle; ptr<=ptr+1; busy<=0.
REQ-011 ptr SHALL wrap from DEPTH-1 to 0.
REQ-012 Timing: total rd-high cycles = 2*(wait_cfg+1); rvalid SHALL rise in the cycle after the final rd cycle, coinciding with ds.
REQ-013 rd=0 while busy=1 SHALL set err and clear busy, phase and cnt; rvalid SHALL NOT pulse.
REQ-014 ds=1 while busy=1 or phase=1 SHALL set err and clear busy, phase and cnt.
REQ-015 err_clr SHALL clear err; err_clr and a new error in the same cycle SHALL leave err=1.
REQ-016 addr_load with busy=0 SHALL set ptr<=addr_in; with busy=1 it SHALL be ignored.
REQ-017 addr_load in the same cycle as the REQ-010 increment SHALL be ignored.
REQ-018 wr_en SHALL write mem[wr_addr] at any time.
REQ-019 A write and a read of the same address in one cycle SHALL return the old data (read-before-write).
REQ-020 rdata SHALL hold its value between rvalid pulses.

Reset
REQ-021 reset_n=0 SHALL asynchronously force busy, phase, cnt, ptr, rvalid and err to 0, rdata to 0, and hence ws to 0.
REQ-022 Memory contents SHALL NOT be reset.
REQ-023 Reset mid-transaction SHALL abort it with no rvalid and no err.

Configuration
REQ-024 With macro RD_TARGET_PARITY_EN defined, an extra output rpar (1 bit) SHALL exist.
REQ-025 rpar SHALL equal the even parity (XOR) of rdata, registered with rdata, and SHALL be 0 at reset.
REQ-026 Without the macro, rpar SHALL NOT exist and behaviour SHALL otherwise be identical.

Structure
REQ-027 Package rd_target_pkg SHALL hold the default DATA_W, DEPTH and WAIT_W constants and a typedef for the phase encoding (P_FIRST, P_SECOND).
REQ-028 Sub-module rd_target_mem SHALL hold the memory: one synchronous write port and one synchronous read port with read-before-write.
REQ-029 All other logic SHALL be in rd_target.

Verification
REQ-030 Preload mem[0..3] with 0x11,0x22,0x33,0x44; wait_cfg=0; one transaction (rd high 2 cycles) -> ws=0 in the DELAY cycle; rvalid with ds; rdata=0x11; ptr=1.
REQ-031 wait_cfg=3, ptr=1 -> ws=1 in DELAY cycles 1-3 and 0 in the 4th; rd high 8 cycles; rdata=0x22.
REQ-032 addr_load addr_in=15; two transactions -> rdata=mem[15], then mem[0] (wrap).
REQ-033 rd dropped after 3 cycles with wait_cfg=2 -> err=1, busy=0, no rvalid; err_clr -> err=0; next transaction is normal.
REQ-034 wr_en to ptr address in the REQ-010 cycle -> old data returned; next read of that address returns the new data.
REQ-035 reset_n pulsed mid-transaction -> all outputs 0 immediately; err=0; a clean transaction follows.
